// File: rtl/frame_painter.sv
// Rectangle fill engine: writes one colour into every on-screen pixel of a clipped
// rectangle, row-major, then hands off through the continuation handshake.
module frame_painter #(
    parameter int SCR_WIDTH        = 160,
    parameter int SCR_HEIGHT       = 120,
    parameter int X_BITS           = 8,
    parameter int Y_BITS           = 7,
    parameter int COLOR_SIZE       = 3,
    parameter int MEMORY_SIZE_BITS = 15
) (
    input  logic                        Clck,
    input  logic                        Reset,
    input  logic                        in_cont_signal,
    input  logic [X_BITS-1:0]           rect_x,
    input  logic [Y_BITS-1:0]           rect_y,
    input  logic [X_BITS-1:0]           rect_w,
    input  logic [Y_BITS-1:0]           rect_h,
    input  logic [COLOR_SIZE-1:0]       fill_colour,
    output logic [MEMORY_SIZE_BITS-1:0] write_addr,
    output logic [COLOR_SIZE-1:0]       write_data,
    output logic                        write_en,
    input  logic                        mem_ready,
    output logic                        busy,
    output logic                        out_cont_signal,
    input  logic                        next_fin_signal
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(SCR_WIDTH);
    localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(SCR_HEIGHT);

    state_t                  state_q;
    logic [X_BITS-1:0]       x_q;
    logic [X_BITS-1:0]       rect_x_q;
    logic [Y_BITS-1:0]       y_q;
    logic [X_BITS:0]         x_end_q;
    logic [Y_BITS:0]         y_end_q;
    logic [COLOR_SIZE-1:0]   colour_q;
    logic                    write_en_q;
    logic                    busy_q;
    logic                    out_cont_q;

    // Extra top bit keeps the edge sums exact before clipping to the screen.
    logic [X_BITS:0] sum_x;
    logic [Y_BITS:0] sum_y;
    logic [X_BITS:0] x_end_d;
    logic [Y_BITS:0] y_end_d;
    logic            empty_d;
    logic            last_col;
    logic            last_row;

    // NOTE: continuous assigns for all combinational terms: each has exactly one
    // unconditional driver, so no latch can be inferred.
    assign sum_x    = {1'b0, rect_x} + {1'b0, rect_w};
    assign sum_y    = {1'b0, rect_y} + {1'b0, rect_h};
    assign x_end_d  = (sum_x > X_LIM) ? X_LIM : sum_x;
    assign y_end_d  = (sum_y > Y_LIM) ? Y_LIM : sum_y;
    assign empty_d  = (rect_w == '0) || (rect_h == '0) ||
                      ({1'b0, rect_x} >= X_LIM) || ({1'b0, rect_y} >= Y_LIM);
    assign last_col = ({1'b0, x_q} == (x_end_q - 1'b1));
    assign last_row = ({1'b0, y_q} == (y_end_q - 1'b1));

    // x_q/y_q reset to 0, so the address is 0 during reset without extra gating.
    assign write_addr      = MEMORY_SIZE_BITS'(y_q) * MEMORY_SIZE_BITS'(SCR_WIDTH)
                           + MEMORY_SIZE_BITS'(x_q);
    assign write_data      = colour_q;
    assign write_en        = write_en_q;
    assign busy            = busy_q;
    assign out_cont_signal = out_cont_q;

    // NOTE: non-blocking assignments only in clocked logic, so every register
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            rect_x_q   <= '0;
            y_q        <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            colour_q   <= '0;
            write_en_q <= 1'b0;
            busy_q     <= 1'b0;
            out_cont_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_cont_signal && !next_fin_signal) begin
                        rect_x_q <= rect_x;
                        x_q      <= rect_x;
                        y_q      <= rect_y;
                        x_end_q  <= x_end_d;
                        y_end_q  <= y_end_d;
                        colour_q <= fill_colour;
                        if (empty_d) begin
                            state_q <= DONE;
                        end else begin
                            state_q    <= WRITE;
                            write_en_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        if (last_col && last_row) begin
                            state_q    <= DONE;
                            write_en_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else if (last_col) begin
                            x_q <= rect_x_q;
                            y_q <= y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Raised one edge after entry; held until downstream reports done.
                    if (next_fin_signal) begin
                        out_cont_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        out_cont_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_painter.sv
// Bench for frame_painter: stimulus pushes expected pixels into a scoreboard queue,
// an independent monitor compares every presented write against it.
module tb_frame_painter;

    logic        Clck = 1'b0;
    logic        Reset;
    logic        in_cont_signal;
    logic [7:0]  rect_x;
    logic [6:0]  rect_y;
    logic [7:0]  rect_w;
    logic [6:0]  rect_h;
    logic [2:0]  fill_colour;
    logic [14:0] write_addr;
    logic [2:0]  write_data;
    logic        write_en;
    logic        mem_ready;
    logic        busy;
    logic        out_cont_signal;
    logic        next_fin_signal;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  data;
    } px_t;

    px_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    frame_painter dut (
        .Clck            (Clck),
        .Reset           (Reset),
        .in_cont_signal  (in_cont_signal),
        .rect_x          (rect_x),
        .rect_y          (rect_y),
        .rect_w          (rect_w),
        .rect_h          (rect_h),
        .fill_colour     (fill_colour),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .write_en        (write_en),
        .mem_ready       (mem_ready),
        .busy            (busy),
        .out_cont_signal (out_cont_signal),
        .next_fin_signal (next_fin_signal)
    );

    always #5 Clck = ~Clck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_px(input int addr, input logic [2:0] data);
        px_t p;
        p.addr = 15'(addr);
        p.data = data;
        exp_q.push_back(p);
    endtask

    // Monitor: every cycle write_en is up, the front of the queue must be on the bus;
    // it is retired only when mem_ready accepts it.
    initial begin
        forever begin
            @(negedge Clck);
            if (Reset === 1'b1 && write_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write: addr=%0d data=%0d, no write expected",
                             write_addr, write_data);
                end else begin
                    check("write_addr", 32'(write_addr), 32'(exp_q[0].addr));
                    check("write_data", 32'(write_data), 32'(exp_q[0].data));
                    if (mem_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic apply_rect(input logic [7:0] x, input logic [6:0] y,
                              input logic [7:0] w, input logic [6:0] h, input logic [2:0] c);
        rect_x      = x;
        rect_y      = y;
        rect_w      = w;
        rect_h      = h;
        fill_colour = c;
    endtask

    // Starts a fill, optionally stalls mem_ready, and checks the handshake timing.
    // exp_cycles counts edges after the start edge until out_cont_signal is seen.
    task automatic run_fill(input int stall_at, input int stall_len, input int exp_cycles);
        int  n;
        bit  seen;
        in_cont_signal = 1'b1;
        @(posedge Clck); #1;
        in_cont_signal = 1'b0;
        check("busy_after_start", 32'(busy), (exp_cycles > 1) ? 32'd1 : 32'd0);
        n    = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(posedge Clck); #1;
            n++;
            if (n == stall_at) mem_ready = 1'b0;
            if (n == stall_at + stall_len) mem_ready = 1'b1;
            if (out_cont_signal) seen = 1;
        end
        mem_ready = 1'b1;
        check("cycles_to_cont", 32'(n), 32'(exp_cycles));
        check("write_en_in_done", 32'(write_en), 32'd0);
        check("pixels_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge Clck);
        #1 check("cont_held", 32'(out_cont_signal), 32'd1);
        next_fin_signal = 1'b1;
        @(posedge Clck); #1;
        check("cont_cleared", 32'(out_cont_signal), 32'd0);
        next_fin_signal = 1'b0;
        @(posedge Clck); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write_en"},   32'(write_en), 32'd0);
        check({tag, "_busy"},       32'(busy), 32'd0);
        check({tag, "_out_cont"},   32'(out_cont_signal), 32'd0);
        check({tag, "_write_addr"}, 32'(write_addr), 32'd0);
        check({tag, "_write_data"}, 32'(write_data), 32'd0);
    endtask

    initial begin
        Reset           = 1'b1;
        in_cont_signal  = 1'b0;
        next_fin_signal = 1'b0;
        mem_ready       = 1'b1;
        apply_rect(8'd0, 7'd0, 8'd0, 7'd0, 3'd0);
        #1 Reset = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge Clck);
        #1 Reset = 1'b1;
        @(posedge Clck); #1;

        // Basic 3x2 fill.
        apply_rect(8'd2, 7'd3, 8'd3, 7'd2, 3'b101);
        expect_px(482, 3'd5); expect_px(483, 3'd5); expect_px(484, 3'd5);
        expect_px(642, 3'd5); expect_px(643, 3'd5); expect_px(644, 3'd5);
        run_fill(0, 0, 7);

        // Clipped at the bottom-right corner.
        apply_rect(8'd158, 7'd119, 8'd5, 7'd4, 3'b010);
        expect_px(19198, 3'd2); expect_px(19199, 3'd2);
        run_fill(0, 0, 3);

        // Stall on the second pixel for three cycles.
        apply_rect(8'd2, 7'd3, 8'd3, 7'd2, 3'b101);
        expect_px(482, 3'd5); expect_px(483, 3'd5); expect_px(484, 3'd5);
        expect_px(642, 3'd5); expect_px(643, 3'd5); expect_px(644, 3'd5);
        run_fill(1, 3, 10);

        // Empty rectangles: zero width, zero height, off-screen x.
        apply_rect(8'd10, 7'd10, 8'd0, 7'd5, 3'b111);
        run_fill(0, 0, 1);
        apply_rect(8'd10, 7'd10, 8'd4, 7'd0, 3'b111);
        run_fill(0, 0, 1);
        apply_rect(8'd200, 7'd10, 8'd10, 7'd5, 3'b111);
        run_fill(0, 0, 1);

        // Single-column fill exercising the row wrap back to the left edge.
        apply_rect(8'd0, 7'd0, 8'd1, 7'd3, 3'b011);
        expect_px(0, 3'd3); expect_px(160, 3'd3); expect_px(320, 3'd3);
        run_fill(0, 0, 4);

        // Reset mid-fill after two accepts.
        apply_rect(8'd2, 7'd3, 8'd3, 7'd2, 3'b101);
        expect_px(482, 3'd5); expect_px(483, 3'd5);
        in_cont_signal = 1'b1;
        @(posedge Clck); #1;
        in_cont_signal = 1'b0;
        @(posedge Clck);
        @(posedge Clck);
        #2 Reset = 1'b0;
        #1 check_all_zero("mid_reset");
        check("mid_reset_accepts", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge Clck);
        #1 Reset = 1'b1;
        repeat (5) @(posedge Clck);
        #1 check("idle_after_reset_write_en", 32'(write_en), 32'd0);
        check("idle_after_reset_busy", 32'(busy), 32'd0);

        // Reset while holding out_cont_signal in DONE.
        apply_rect(8'd10, 7'd10, 8'd0, 7'd5, 3'b001);
        in_cont_signal = 1'b1;
        @(posedge Clck); #1;
        in_cont_signal = 1'b0;
        @(posedge Clck); #1;
        check("done_before_reset", 32'(out_cont_signal), 32'd1);
        Reset = 1'b0;
        #1 check("done_reset_out_cont", 32'(out_cont_signal), 32'd0);
        @(posedge Clck); #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clck);
        #1 check("done_reset_stays_low", 32'(out_cont_signal), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
